noc_local_injector: RTL and testbench

- Packet source for one router's local port in the mesh.
- Takes a packet command (target XY, payload length) and a stream of payload words.
- Buffers the payload words in an internal FIFO.
- Serialises header, size and payload flits onto the router's local rx/data_in input, honouring the router's local credit_o.
- One instance per router; an instance drives rxLocal[i] and data_inLocal_flit[i], and consumes credit_oLocal[i].

---
 rtl/noc_local_injector_pkg.sv | 20 ++
 rtl/noc_inj_fifo.sv | 54 +++++
 rtl/noc_local_injector.sv | 167 ++++++++++++++++
 tb/tb_noc_local_injector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_local_injector_pkg.sv
// Shared constants and FSM encoding for the local-port packet injector.
// The SRC state exists only when NOC_INJ_SRC_TAG_EN is defined.
package noc_local_injector_pkg;

    localparam int INJ_TAM_FLIT   = 16;
    localparam int INJ_METADEFLIT = 4;
    localparam int NROT           = 16;
    localparam int NPORT          = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_SIZE    = 3'd2,
`ifdef NOC_INJ_SRC_TAG_EN
        S_SRC     = 3'd3,
`endif
        S_PAYLOAD = 3'd4
    } inj_state_e;

endpackage

// File: rtl/noc_inj_fifo.sv
// Synchronous payload FIFO for the injector; head is the word at the read pointer.
// Flush clears occupancy synchronously; memory contents are left as they are.
module noc_inj_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer update with synchronous flush.
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage write.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/noc_local_injector.sv
// Local-port packet injector: header, size and buffered payload flits toward one router.
// Optional NOC_INJ_SRC_TAG_EN adds a SRC flit (SRC_ADDR) ahead of the payload.
module noc_local_injector
    import noc_local_injector_pkg::*;
#(
    parameter int TAM_FLIT   = INJ_TAM_FLIT,
    parameter int METADEFLIT = INJ_METADEFLIT,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_SIZE   = 255
`ifdef NOC_INJ_SRC_TAG_EN
    ,
    parameter int SRC_ADDR   = 0
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2*METADEFLIT-1:0] cmd_target,
    input  logic [TAM_FLIT-1:0]     cmd_size,
    input  logic                    pl_valid,
    output logic                    pl_ready,
    input  logic [TAM_FLIT-1:0]     pl_data,
    output logic                    rx_o,
    output logic [TAM_FLIT-1:0]     data_o,
    input  logic                    credit_i,
    output logic                    busy,
    output logic                    pkt_done
);

    localparam logic [TAM_FLIT-1:0] CNT_ZERO = {TAM_FLIT{1'b0}};
    localparam logic [TAM_FLIT-1:0] CNT_ONE  = TAM_FLIT'(1);
    localparam logic [TAM_FLIT-1:0] SIZE_MAX = TAM_FLIT'(MAX_SIZE);

    inj_state_e                state_r;
    inj_state_e                state_s;
    logic [2*METADEFLIT-1:0]   target_r;
    logic [TAM_FLIT-1:0]       remain_r;
    logic [TAM_FLIT-1:0]       size_clip_s;
    logic                      accept_s;
    logic                      xfer_s;
    logic                      fifo_push_s;
    logic                      fifo_pop_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic [TAM_FLIT-1:0]       fifo_head_s;

    assign accept_s    = cmd_valid && cmd_ready;
    assign xfer_s      = rx_o && credit_i;
    assign size_clip_s = (cmd_size > SIZE_MAX) ? SIZE_MAX : cmd_size;
    assign fifo_push_s = pl_valid && pl_ready;

    noc_inj_fifo #(
        .WIDTH (TAM_FLIT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .flush (reset),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (pl_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (fifo_head_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_s = S_HEADER;
                else          state_s = S_IDLE;
            end
            S_HEADER: begin
                if (xfer_s) state_s = S_SIZE;
                else        state_s = S_HEADER;
            end
            S_SIZE: begin
`ifdef NOC_INJ_SRC_TAG_EN
                if (xfer_s) state_s = S_SRC;
                else        state_s = S_SIZE;
            end
            S_SRC: begin
`endif
                if (xfer_s) state_s = (remain_r != CNT_ZERO) ? S_PAYLOAD : S_IDLE;
                else        state_s = state_r;
            end
            S_PAYLOAD: begin
                if (xfer_s && (remain_r == CNT_ONE)) state_s = S_IDLE;
                else                                 state_s = S_PAYLOAD;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM outputs; pkt_done is qualified directly by credit_i to stay off rx_o.
    always_comb begin
        rx_o       = 1'b0;
        data_o     = CNT_ZERO;
        pkt_done   = 1'b0;
        fifo_pop_s = 1'b0;
        busy       = (state_r != S_IDLE);
        cmd_ready  = (state_r == S_IDLE) && !reset;
        pl_ready   = !fifo_full_s && !reset;
        case (state_r)
            S_IDLE: begin
                rx_o = 1'b0;
            end
            S_HEADER: begin
                rx_o   = 1'b1;
                data_o = TAM_FLIT'(target_r);
            end
            S_SIZE: begin
                rx_o = 1'b1;
`ifdef NOC_INJ_SRC_TAG_EN
                data_o = remain_r + CNT_ONE;
`else
                data_o   = remain_r;
                pkt_done = credit_i && (remain_r == CNT_ZERO);
`endif
            end
`ifdef NOC_INJ_SRC_TAG_EN
            S_SRC: begin
                rx_o     = 1'b1;
                data_o   = TAM_FLIT'(SRC_ADDR);
                pkt_done = credit_i && (remain_r == CNT_ZERO);
            end
`endif
            S_PAYLOAD: begin
                rx_o       = !fifo_empty_s;
                data_o     = fifo_head_s;
                fifo_pop_s = !fifo_empty_s && credit_i;
                pkt_done   = !fifo_empty_s && credit_i && (remain_r == CNT_ONE);
            end
            default: begin
                rx_o = 1'b0;
            end
        endcase
    end

    // Packet target and remaining payload count.
    always_ff @(posedge clock) begin
        if (reset) begin
            target_r <= '0;
            remain_r <= CNT_ZERO;
        end else if (accept_s) begin
            target_r <= cmd_target;
            remain_r <= size_clip_s;
        end else if (fifo_pop_s) begin
            remain_r <= remain_r - CNT_ONE;
        end else begin
            target_r <= target_r;
            remain_r <= remain_r;
        end
    end

endmodule

// File: tb/tb_noc_local_injector.sv
// Self-checking bench for noc_local_injector (default build): directed and random
// packets checked against a packet-level model of header/size/payload ordering.
module tb_noc_local_injector;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_target;
    logic [15:0] cmd_size;
    logic        pl_valid;
    logic        pl_ready;
    logic [15:0] pl_data;
    logic        rx_o;
    logic [15:0] data_o;
    logic        credit_i;
    logic        busy;
    logic        pkt_done;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] pend[$];
    logic [15:0] model_pl[$];
    int          last_cycles;
    int          last_bubbles;

    noc_local_injector dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_size   (cmd_size),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .pl_data    (pl_data),
        .rx_o       (rx_o),
        .data_o     (data_o),
        .credit_i   (credit_i),
        .busy       (busy),
        .pkt_done   (pkt_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Push everything pending while the injector sits idle.
    task automatic preload();
        for (int c = 0; c < 64 && pend.size() > 0; c++) begin
            pl_valid = 1'b1;
            pl_data  = pend[0];
            #1;
            if (pl_ready) model_pl.push_back(pend.pop_front());
            tick();
        end
        pl_valid = 1'b0;
        #1;
    endtask

    // Issue one command, stream payload from pend, collect flits, compare with model.
    task automatic run(input logic [7:0] tgt, input logic [15:0] sz, input int delay, input int cmode);
        logic [15:0] expq[$];
        logic [15:0] got[$];
        logic [15:0] prev_d;
        logic        prev_rx, prev_cr;
        int          s, cyc, w, stall_err, busy_err, done_cnt, done_pos, bubbles;
        bit          done;
        stall_err = 0; busy_err = 0; done_cnt = 0; done_pos = -1; bubbles = 0;
        done = 1'b0; prev_rx = 1'b0; prev_cr = 1'b0; prev_d = 16'h0000;
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_size   = sz;
        #1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_size  = 16'($urandom);
        for (cyc = 0; cyc < 3000 && !done; cyc++) begin
            case (cmode)
                0:       credit_i = 1'b1;
                1:       credit_i = ($urandom_range(0, 3) != 0);
                default: credit_i = !(cyc >= 1 && cyc <= 4);
            endcase
            pl_valid = (cyc >= delay) && (pend.size() > 0);
            pl_data  = (pend.size() > 0) ? pend[0] : 16'h0000;
            #1;
            if (cyc == 0) begin
                chk("hdr_latency_rx", {31'd0, rx_o}, 32'd1);
                chk("hdr_latency_data", {16'd0, data_o}, {24'd0, tgt});
            end
            if (cyc > 0 && prev_rx && !prev_cr && (rx_o !== 1'b1 || data_o !== prev_d)) stall_err++;
            if (busy !== 1'b1) busy_err++;
            if (rx_o !== 1'b1) bubbles++;
            if (rx_o === 1'b1 && credit_i) got.push_back(data_o);
            if (pkt_done === 1'b1) begin
                done_cnt++;
                done_pos = got.size();
                done = 1'b1;
            end
            if (pl_valid && pl_ready) model_pl.push_back(pend.pop_front());
            prev_rx = rx_o; prev_cr = credit_i; prev_d = data_o;
            tick();
        end
        pl_valid = 1'b0;
        credit_i = 1'b0;
        #1;
        last_cycles  = cyc;
        last_bubbles = bubbles;
        chk("pkt_timeout", {31'd0, done}, 32'd1);
        chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("stall_stable", stall_err, 32'd0);
        chk("busy_held", busy_err, 32'd0);
        chk("done_count", done_cnt, 32'd1);
        // Model: header {x,y}, clipped size, then that many words in push order.
        s = (sz > 16'd255) ? 255 : int'(sz);
        expq.push_back({8'h00, tgt});
        expq.push_back(16'(s));
        for (int i = 0; i < s; i++) begin
            if (model_pl.size() > 0) expq.push_back(model_pl.pop_front());
        end
        chk("done_pos", done_pos, expq.size());
        chk("flit_count", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk($sformatf("flit[%0d]", i), {16'd0, got[i]}, {16'd0, expq[i]});
        end
    endtask

    initial begin
        int sz;
        reset = 1'b1; cmd_valid = 1'b0; cmd_target = 8'h00; cmd_size = 16'h0000;
        pl_valid = 1'b0; pl_data = 16'h0000; credit_i = 1'b0;
        tick(); tick(); tick();
        chk("rst_rx", {31'd0, rx_o}, 32'd0);
        chk("rst_data", {16'd0, data_o}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_pl_ready", {31'd0, pl_ready}, 32'd1);

        // Preloaded packet at full credit: five consecutive flits.
        pend = '{16'h00A1, 16'h00A2, 16'h00A3};
        preload();
        run(8'h12, 16'd3, 0, 0);
        chk("consecutive", last_cycles, 32'd5);

        // Same packet with credit withheld during SIZE.
        pend = '{16'h00A1, 16'h00A2, 16'h00A3};
        preload();
        run(8'h12, 16'd3, 0, 2);

        // Late payload forces bubbles without aborting.
        pend = '{16'h00B1, 16'h00B2};
        run(8'h34, 16'd2, 3, 0);
        chk("bubble_seen", {31'd0, last_bubbles != 0}, 32'd1);

        // Zero-size packet: header and size only.
        run(8'h56, 16'd0, 0, 0);

        // Fill the FIFO, then reset in the middle of PAYLOAD.
        for (int i = 0; i < 16; i++) pend.push_back(16'($urandom));
        preload();
        chk("fifo_full", {31'd0, pl_ready}, 32'd0);
        cmd_valid = 1'b1; cmd_target = 8'h78; cmd_size = 16'd16; credit_i = 1'b1;
        #1;
        chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("mid_hdr", {16'd0, data_o}, 32'h0078);
        tick();
        chk("mid_size", {16'd0, data_o}, 32'd16);
        tick();
        chk("mid_pl0", {16'd0, data_o}, {16'd0, model_pl[0]});
        tick();
        chk("mid_pl1", {16'd0, data_o}, {16'd0, model_pl[1]});
        credit_i = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_rx", {31'd0, rx_o}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_pl_ready", {31'd0, pl_ready}, 32'd1);
        model_pl.delete();
        // A flushed FIFO must deliver only the freshly pushed word.
        pend = '{16'h0C0D};
        run(8'h9A, 16'd1, 2, 0);

        // Oversized command is clipped to 255 payload flits.
        for (int i = 0; i < 255; i++) pend.push_back(16'($urandom));
        run(8'hBC, 16'd300, 0, 1);

        // Random packets.
        for (int k = 0; k < 8; k++) begin
            sz = $urandom_range(0, 24);
            for (int i = 0; i < sz; i++) pend.push_back(16'($urandom));
            run(8'($urandom), 16'(sz), $urandom_range(0, 6), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
